// File: rtl/sobel_stream.sv
// rtl/sobel_stream.sv - streaming 3x3 Sobel |Gx|+|Gy| with line buffers and 2-stage pipeline
// Optional binarisation against thresh is enabled by defining SOBEL_THRESH_EN.
module sobel_stream #(
   parameter int PIX_W      = 8,
   parameter int IMG_W      = 352,
   parameter int IMG_H      = 288,
   parameter int NORM_SHIFT = 3
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [PIX_W-1:0] in_pixel,
`ifdef SOBEL_THRESH_EN
   input  logic [PIX_W-1:0] thresh,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [PIX_W-1:0] out_pixel,
   output logic             out_last
);
   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   localparam int GW = PIX_W + 4;
   localparam logic [GW-1:0] MAXV = {{4{1'b0}}, {PIX_W{1'b1}}};

   logic en;
   logic accept;
   logic [CW-1:0] col;
   logic [RW-1:0] row;
   logic [PIX_W-1:0] buf0 [0:IMG_W-1];
   logic [PIX_W-1:0] buf1 [0:IMG_W-1];
   logic [PIX_W-1:0] s11, s21, s31, s12, s22, s32;
   logic [PIX_W-1:0] s13, s23, s33;
   logic win_ok;
   logic win_last;
   logic signed [GW-1:0] gx_n, gy_n;
   logic signed [GW-1:0] gx, gy;
   logic v1, last1;
   logic [GW-1:0] ax, ay, mag, nrm;
   logic [PIX_W-1:0] sat, res;

   function automatic logic signed [GW-1:0] ext(input logic [PIX_W-1:0] p);
      return $signed({4'b0000, p});
   endfunction

   assign en       = !out_valid || out_ready;
   assign in_ready = en;
   assign accept   = in_valid && en;

   // The newest window column comes straight from the buffers and the input,
   // so only the two older columns need registers and stage 1 sees the window
   // completed by the pixel being accepted.
   assign s13 = buf0[col];
   assign s23 = buf1[col];
   assign s33 = in_pixel;

   assign win_ok   = (row >= RW'(2)) && (col >= CW'(2));
   assign win_last = win_ok && (row == RW'(IMG_H-1)) && (col == CW'(IMG_W-1));

   assign gx_n = (ext(s13) + (ext(s23) <<< 1) + ext(s33))
               - (ext(s11) + (ext(s21) <<< 1) + ext(s31));
   assign gy_n = (ext(s11) + (ext(s12) <<< 1) + ext(s13))
               - (ext(s31) + (ext(s32) <<< 1) + ext(s33));

   assign ax  = gx[GW-1] ? $unsigned(-gx) : $unsigned(gx);
   assign ay  = gy[GW-1] ? $unsigned(-gy) : $unsigned(gy);
   assign mag = ax + ay;
   assign nrm = mag >> NORM_SHIFT;
   assign sat = (nrm > MAXV) ? {PIX_W{1'b1}} : nrm[PIX_W-1:0];
`ifdef SOBEL_THRESH_EN
   assign res = (sat >= thresh) ? {PIX_W{1'b1}} : {PIX_W{1'b0}};
`else
   assign res = sat;
`endif

   // Buffers and window carry no reset; row/col gating keeps stale data unused.
   always_ff @(posedge clk) begin
      if (accept) begin
         buf0[col] <= buf1[col];
         buf1[col] <= in_pixel;
         s11 <= s12;
         s21 <= s22;
         s31 <= s32;
         s12 <= s13;
         s22 <= s23;
         s32 <= s33;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         col       <= '0;
         row       <= '0;
         v1        <= 1'b0;
         last1     <= 1'b0;
         gx        <= '0;
         gy        <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_pixel <= '0;
      end else if (en) begin
         if (accept) begin
            if (col == CW'(IMG_W-1)) begin
               col <= '0;
               row <= (row == RW'(IMG_H-1)) ? '0 : row + 1'b1;
            end else begin
               col <= col + 1'b1;
            end
         end
         v1        <= accept && win_ok;
         last1     <= accept && win_last;
         gx        <= gx_n;
         gy        <= gy_n;
         out_valid <= v1;
         out_last  <= v1 && last1;
         out_pixel <= res;
      end
   end
endmodule

// File: tb/tb_sobel_stream.sv
// tb/tb_sobel_stream.sv - self-checking bench for sobel_stream on three frame geometries
module tb_sobel_stream;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset_n;
   logic [2:0] in_valid, in_ready, out_valid, out_ready, out_last;
   logic [7:0] in_pixel  [3];
   logic [7:0] out_pixel [3];
`ifdef SOBEL_THRESH_EN
   logic [7:0] thresh_v = 8'd127;
   localparam logic [7:0] VERT_EXP   = 8'd255;
   localparam logic [7:0] CORNER_EXP = 8'd255;
`else
   localparam logic [7:0] VERT_EXP   = 8'd127;
   localparam logic [7:0] CORNER_EXP = 8'd191;
`endif

   int checks = 0;
   int failures = 0;
   int img [0:7][0:7];
   logic [8:0] exp_mem [3][0:255];
   logic [8:0] cap     [3][0:255];
   int wr [3];
   int rd [3];
   logic stall_p [3];
   logic [8:0] held [3];
   int hold = 0;
   int low_seen = 0;
   logic rnd_ready = 1'b0;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int GW  = (g == 0) ? 4 : (g == 1) ? 3 : 6;
      localparam int GH  = (g == 0) ? 4 : (g == 1) ? 3 : 5;
      localparam int GNS = (g == 2) ? 1 : 3;
      sobel_stream #(.PIX_W(8), .IMG_W(GW), .IMG_H(GH), .NORM_SHIFT(GNS)) u_dut (
         .clk       (clk),
         .reset_n   (reset_n),
         .in_valid  (in_valid[g]),
         .in_ready  (in_ready[g]),
         .in_pixel  (in_pixel[g]),
`ifdef SOBEL_THRESH_EN
         .thresh    (thresh_v),
`endif
         .out_valid (out_valid[g]),
         .out_ready (out_ready[g]),
         .out_pixel (out_pixel[g]),
         .out_last  (out_last[g])
      );
   end

   function automatic int fw(int d);
      return (d == 0) ? 4 : (d == 1) ? 3 : 6;
   endfunction
   function automatic int fh(int d);
      return (d == 0) ? 4 : (d == 1) ? 3 : 5;
   endfunction
   function automatic int fns(int d);
      return (d == 2) ? 1 : 3;
   endfunction

   // Reference: direct 3x3 convolution around centre (r,c) of the stored image.
   function automatic logic [8:0] model_px(int d, int r, int c);
      int gx, gy, m;
      gx = (img[r-1][c+1] + 2*img[r][c+1] + img[r+1][c+1])
         - (img[r-1][c-1] + 2*img[r][c-1] + img[r+1][c-1]);
      gy = (img[r-1][c-1] + 2*img[r-1][c] + img[r-1][c+1])
         - (img[r+1][c-1] + 2*img[r+1][c] + img[r+1][c+1]);
      m = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
      m = m >> fns(d);
      if (m > 255) m = 255;
`ifdef SOBEL_THRESH_EN
      m = (m >= int'(thresh_v)) ? 255 : 0;
`endif
      return {(r == fh(d) - 2) && (c == fw(d) - 2), 8'(m)};
   endfunction

   task automatic expect_eq(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic fill_img(int d, int pat);
      for (int r = 0; r < fh(d); r++)
         for (int c = 0; c < fw(d); c++)
            case (pat)
               0:       img[r][c] = int'($urandom_range(0, 255));
               1:       img[r][c] = 100;
               2:       img[r][c] = (c >= 2) ? 255 : 0;
               default: img[r][c] = ((r == 0 && c >= 1) || (r == 1 && c == 2)) ? 255 : 0;
            endcase
   endtask

   task automatic push_pixel(int d, logic [7:0] p);
      int b;
      logic acc;
      b = 0;
      acc = 1'b0;
      in_valid[d] = 1'b1;
      in_pixel[d] = p;
      while (!acc && b < 300) begin
         @(negedge clk);
         acc = in_ready[d];
         @(posedge clk); #1;
         b++;
      end
      in_valid[d] = 1'b0;
      if (!acc) begin
         checks++;
         failures++;
         $display("FAIL push_timeout dut%0d", d);
      end
   endtask

   task automatic send_frame(int d, int n_pix, bit gaps, bit expect_out);
      int idx;
      if (expect_out)
         for (int r = 1; r < fh(d) - 1; r++)
            for (int c = 1; c < fw(d) - 1; c++) begin
               exp_mem[d][wr[d] % 256] = model_px(d, r, c);
               wr[d]++;
            end
      idx = 0;
      for (int r = 0; r < fh(d); r++)
         for (int c = 0; c < fw(d); c++)
            if (idx < n_pix) begin
               if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
               push_pixel(d, 8'(img[r][c]));
               idx++;
            end
   endtask

   task automatic drain(int d);
      int b;
      b = 0;
      while (rd[d] != wr[d] && b < 500) begin
         @(negedge clk);
         b++;
      end
      expect_eq($sformatf("drain_pending_dut%0d", d), wr[d] - rd[d], 0);
      @(posedge clk); #1;
   endtask

   initial begin
      out_ready = 3'b111;
      forever begin
         @(posedge clk); #1;
         for (int d = 0; d < 3; d++)
            out_ready[d] = (hold > 0 && d == 2) ? 1'b0 :
                           (rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1);
         if (hold > 0) hold--;
      end
   end

   // Scoreboard, handshake and stall-stability checks on every cycle.
   always @(negedge clk) begin
      for (int d = 0; d < 3; d++) begin
         if (!reset_n) begin
            stall_p[d] = 1'b0;
         end else begin
            checks++;
            if (in_ready[d] !== (!out_valid[d] || out_ready[d])) begin
               failures++;
               $display("FAIL in_ready_dut%0d: got %0b expected %0b", d, in_ready[d],
                        !out_valid[d] || out_ready[d]);
            end
            if (stall_p[d]) begin
               checks++;
               if (!out_valid[d] || {out_last[d], out_pixel[d]} !== held[d]) begin
                  failures++;
                  $display("FAIL stall_hold_dut%0d: got valid=%0b %0h expected valid=1 %0h",
                           d, out_valid[d], {out_last[d], out_pixel[d]}, held[d]);
               end
            end
            if (d == 2 && hold_window() && out_valid[2] && !in_ready[2]) low_seen++;
            if (out_valid[d] && out_ready[d]) begin
               checks++;
               if (rd[d] == wr[d]) begin
                  failures++;
                  $display("FAIL extra_out_dut%0d: got pix=%0d expected no output", d, out_pixel[d]);
               end else begin
                  cap[d][rd[d] % 256] = {out_last[d], out_pixel[d]};
                  if ({out_last[d], out_pixel[d]} !== exp_mem[d][rd[d] % 256]) begin
                     failures++;
                     $display("FAIL out_dut%0d[%0d]: got last=%0b pix=%0d expected last=%0b pix=%0d",
                              d, rd[d], out_last[d], out_pixel[d],
                              exp_mem[d][rd[d] % 256][8], exp_mem[d][rd[d] % 256][7:0]);
                  end
                  rd[d]++;
               end
            end
            stall_p[d] = out_valid[d] && !out_ready[d];
            held[d]    = {out_last[d], out_pixel[d]};
         end
      end
   end

   function automatic bit hold_window();
      return !out_ready[2] && !rnd_ready;
   endfunction

   initial begin
      #600000;
      failures++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      int base;
      reset_n  = 1'b0;
      in_valid = 3'b000;
      for (int d = 0; d < 3; d++) begin
         in_pixel[d] = 8'd0;
         wr[d] = 0;
         rd[d] = 0;
         stall_p[d] = 1'b0;
      end
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         expect_eq($sformatf("reset_out_valid_dut%0d", d), int'(out_valid[d]), 0);
         expect_eq($sformatf("reset_out_last_dut%0d", d), int'(out_last[d]), 0);
         expect_eq($sformatf("reset_out_pixel_dut%0d", d), int'(out_pixel[d]), 0);
         expect_eq($sformatf("reset_in_ready_dut%0d", d), int'(in_ready[d]), 1);
      end
      @(posedge clk); #1;

      // Hand-computed pins of the reference model.
      fill_img(0, 1);
      expect_eq("model_flat", int'(model_px(0, 1, 1)), 0);
      fill_img(0, 2);
      expect_eq("model_vert", int'(model_px(0, 2, 2)), int'({1'b1, VERT_EXP}));
      fill_img(1, 3);
      expect_eq("model_corner", int'(model_px(1, 1, 1)), int'({1'b1, CORNER_EXP}));
      fill_img(2, 2);
      expect_eq("model_vert_sat", int'(model_px(2, 1, 2)), 255);
      expect_eq("model_vert_flat_side", int'(model_px(2, 1, 3)), 0);

      // Flat 4x4: four zeros, last only on the fourth.
      fill_img(0, 1);
      base = wr[0];
      send_frame(0, 16, 1'b0, 1'b1);
      drain(0);
      for (int i = 0; i < 4; i++)
         expect_eq($sformatf("flat_out%0d", i), int'(cap[0][base + i]), int'({i == 3, 8'd0}));

      // Vertical edge 4x4.
      fill_img(0, 2);
      base = wr[0];
      send_frame(0, 16, 1'b0, 1'b1);
      drain(0);
      for (int i = 0; i < 4; i++)
         expect_eq($sformatf("vert_out%0d", i), int'(cap[0][base + i]), int'({i == 3, VERT_EXP}));

      // Corner 3x3, including the two-cycle latency after the completing pixel.
      fill_img(1, 3);
      base = wr[1];
      send_frame(1, 9, 1'b0, 1'b1);
      @(negedge clk);
      expect_eq("corner_latency_c1", int'(out_valid[1]), 0);
      @(negedge clk);
      expect_eq("corner_latency_c2", int'(out_valid[1]), 1);
      drain(1);
      expect_eq("corner_out", int'(cap[1][base]), int'({1'b1, CORNER_EXP}));

      // Vertical edge 6x5 with NORM_SHIFT=1 saturates.
      fill_img(2, 2);
      base = wr[2];
      send_frame(2, 30, 1'b0, 1'b1);
      drain(2);
      expect_eq("vert_sat_out0", int'(cap[2][base]), 255);

      // Backpressure mid-stream on a random 6x5 frame.
      fill_img(2, 0);
      base = wr[2];
      low_seen = 0;
      fork
         send_frame(2, 30, 1'b0, 1'b1);
         begin
            int b;
            b = 0;
            while (!out_valid[2] && b < 200) begin @(negedge clk); b++; end
            repeat (2) @(negedge clk);
            hold = 5;
         end
      join
      drain(2);
      expect_eq("bp_count", rd[2] - base, 12);
      expect_eq("bp_in_ready_low_seen", int'(low_seen > 0), 1);

      // Back-to-back random frames with input gaps and random downstream stalls.
      rnd_ready = 1'b1;
      for (int f = 0; f < 3; f++)
         for (int d = 0; d < 3; d++) begin
            fill_img(d, 0);
            send_frame(d, fw(d) * fh(d), f[0], 1'b1);
         end
      for (int d = 0; d < 3; d++) drain(d);
      rnd_ready = 1'b0;
      repeat (2) begin @(posedge clk); #1; end

      // Reset after 7 pixels of a frame, then a clean frame.
      fill_img(0, 0);
      send_frame(0, 7, 1'b0, 1'b0);
      reset_n = 1'b0;
      @(posedge clk); #1;
      reset_n = 1'b1;
      for (int d = 0; d < 3; d++) wr[d] = rd[d];
      @(negedge clk);
      expect_eq("midreset_out_valid", int'(out_valid[0]), 0);
      @(posedge clk); #1;
      fill_img(0, 0);
      base = wr[0];
      send_frame(0, 16, 1'b1, 1'b1);
      drain(0);
      expect_eq("midreset_count", rd[0] - base, 4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/sobel_stream.md
# sobel_stream

Streaming, parametrised successor to the combinational Sobel operator. It accepts a raster-order pixel stream, keeps two line buffers plus a 3x3 window internally, and computes |Gx|+|Gy| through a 2-stage pipeline. The result is normalised and saturated to the pixel width, and one result is emitted per interior pixel with valid/ready backpressure. It sits between the pixel fetch stage and the result writer of the edge-detection accelerator.

## Interface
- PIX_W, 8, pixel width in bits for input and output
- IMG_W, 352, pixels per line; line buffer depth; must be ≥3
- IMG_H, 288, lines per frame; must be ≥3
- NORM_SHIFT, 3, right shift applied to magnitude before saturation

Ports:
- clk  in  1  clock; all logic is rising-edge
- reset_n  in  1  synchronous, active-low reset
- in_valid  in  1  in_pixel is valid
- in_ready  out  1  block accepts in_pixel this cycle
- in_pixel  in  PIX_W  unsigned pixel, raster order
- out_valid  out  1  out_pixel is valid
- out_ready  in  1  downstream accepts out_pixel
- out_pixel  out  PIX_W  normalised edge magnitude
- out_last  out  1  marks the final output of a frame
- thresh  in  PIX_W  binarisation threshold; present only with SOBEL_THRESH_EN

## Operation
- **Input accept:** a pixel is accepted when in_valid && in_ready.
- **Counters:** the col counter (0..IMG_W-1) and row counter (0..IMG_H-1) advance on each accept.
  - col wraps to 0 and row increments.
  - After (IMG_H-1, IMG_W-1) both wrap to 0, starting the next frame. No gap is required between frames.
- **Line buffers:** two IMG_W-deep buffers hold rows r-1 and r-2, indexed by col. On each accept, buffer1[col] moves to buffer0[col] and in_pixel is written to buffer1[col].
- **Window:** a 3x3 shift register is fed with column {buffer0[col], buffer1[col], in_pixel}, ordered top to bottom.
  - Naming: s11 is top-left, s13 is top-right, s31 is bottom-left, s33 is bottom-right.
  - The window is valid when row≥2 && col≥2. Its centre is pixel (row-1, col-1).
- **Outputs per frame:** exactly (IMG_W-2)*(IMG_H-2). Border pixels produce no output.
- **Stage 1 (registered):**
  - gx = (s13+2·s23+s33) − (s11+2·s21+s31)
  - gy = (s11+2·s12+s13) − (s31+2·s32+s33)
  - Both are signed, PIX_W+4 bits, and never overflow.
- **Stage 2 (registered):**
  - mag = |gx|+|gy|, unsigned PIX_W+4 bits.
  - n = mag >> NORM_SHIFT.
  - out_pixel = (n > 2^PIX_W−1) ? 2^PIX_W−1 : n.
- **out_last:** set with the output whose window centre is (IMG_H-2, IMG_W-2).
- **Pipeline advance:** the pipeline advances when en = !out_valid || out_ready, and in_ready = en.
  - When en=0, all state holds, including counters, buffers, window and both stages. Stalled data is never lost or duplicated.
- **Reset (reset_n=0 at a clock edge):**
  - Counters go to 0. The valid bits of stage 1 and stage 2 are cleared.
  - Outputs: out_valid=0, out_last=0, out_pixel=0, in_ready=1 on the cycle after reset.
  - Line buffer and window contents are not cleared. They are never consumed before being rewritten, because of the row≥2/col≥2 gating.
- **Reset mid-frame:** the partial frame is discarded. The next accepted pixel is (0,0).

## Timing
- **Latency:** the output for a window appears with out_valid=1 two cycles after the accept of the pixel that completes it, assuming no stall.
- **Throughput:** 1 pixel/cycle while out_ready=1.
- **Output stability:** out_pixel and out_last stay stable while out_valid && !out_ready.
- **in_ready:** combinational from out_valid and out_ready. There is no combinational path from in_valid to any output.

## Configuration
- **SOBEL_THRESH_EN defined:**
  - The thresh port exists.
  - Stage 2 outputs 2^PIX_W−1 if the saturated value ≥ thresh, else 0.
  - Latency is unchanged.
- **SOBEL_THRESH_EN undefined:** the thresh port is absent and out_pixel is the saturated magnitude.

## Test plan
- **Flat image:** IMG_W=4, IMG_H=4, all pixels 100, out_ready=1 → 4 outputs, all 0; out_last on the 4th only.
- **Vertical edge:** IMG_W=4, IMG_H=4, columns 0,0,255,255 → 4 outputs of 127 (mag 1020>>3). With NORM_SHIFT=1 → 4 outputs of 255 (saturation).
- **Corner pattern:** IMG_W=3, IMG_H=3, s12=s13=s23=255, others 0 → one output of 191 (mag 1530) with out_last=1.
- **Backpressure:** on a 6x5 random frame, hold out_ready low 5 cycles mid-stream.
  - out_pixel stays stable and in_ready goes low.
  - 12 outputs match the reference model in order, with no drops.
- **Reset mid-frame:** pulse reset_n low for 1 cycle after 7 pixels of a 4x4 frame.
  - out_valid=0 the next cycle.
  - A following full 4x4 frame yields exactly 4 correct outputs.
- **SOBEL_THRESH_EN, thresh=128:** the vertical-edge frame gives 4 outputs of 0; with thresh=127 it gives 4 outputs of 255.
